// File: rtl/led_seq_pkg.sv
// Shared types for the LED pattern sequencer: mode codes and bounce direction.
package led_seq_pkg;

   localparam int MODE_W = 3;

   // Codes 5..6 are not named; every unnamed code behaves like MODE_HOLD.
   typedef enum logic [MODE_W-1:0] {
      MODE_ROTL   = 3'd0,
      MODE_ROTR   = 3'd1,
      MODE_BOUNCE = 3'd2,
      MODE_FILL   = 3'd3,
      MODE_BLINK  = 3'd4,
      MODE_HOLD   = 3'd7
   } mode_e;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

endpackage

// File: rtl/led_prescaler.sv
// Step prescaler: counts up to the period register and fires a one-cycle tick.
module led_prescaler #(
   parameter int          DIV_W       = 32,
   parameter int unsigned DEFAULT_DIV = 5000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pause,
   input  logic             apply,
   input  logic [DIV_W-1:0] div_new,
   output logic             tick
);

   logic [DIV_W-1:0] count_r;
   logic [DIV_W-1:0] div_r;

   // Equality compare lets an all-ones period run without overflow.
   assign tick = !pause && (count_r == div_r);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_r <= '0;
         div_r   <= DIV_W'(DEFAULT_DIV);
      end else if (apply) begin
         count_r <= '0;
         div_r   <= div_new;
      end else if (tick) begin
         count_r <= '0;
      end else if (!pause) begin
         count_r <= count_r + DIV_W'(1);
      end
   end

endmodule

// File: rtl/led_seq.sv
// LED pattern sequencer: config handshake with step-boundary apply, animation datapath.
//   state          | meaning
//   dir_r  LEFT    | bounce moving toward the MSB
//   dir_r  RIGHT   | bounce moving toward bit 0
//   phase_r 0 / 1  | fill: filling / draining ; blink: pattern shown / dark
module led_seq
   import led_seq_pkg::*;
#(
   parameter int          WIDTH       = 16,
   parameter int          DIV_W       = 32,
   parameter int unsigned DEFAULT_DIV = 5000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pause,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [MODE_W-1:0] cfg_mode,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [WIDTH-1:0]  cfg_pattern,
   output logic [WIDTH-1:0]  led,
   output logic              step,
   output logic [MODE_W-1:0] mode
);

   logic              tick;
   logic              accept;
   logic              apply;
   logic              pending;
   logic [MODE_W-1:0] pend_mode;
   logic [DIV_W-1:0]  pend_div;
   logic [WIDTH-1:0]  pend_pattern;

   logic [WIDTH-1:0]  led_r;
   logic [WIDTH-1:0]  led_nxt;
   logic [WIDTH-1:0]  pat_r;
   logic [MODE_W-1:0] mode_r;
   dir_e              dir_r;
   dir_e              dir_nxt;
   logic              phase_r;
   logic              phase_nxt;

   assign accept = cfg_valid && cfg_ready;
   // While paused no tick will come, so a pending config lands on the next cycle.
   assign apply  = pending && (tick || pause);

   led_prescaler #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_prescaler (
      .clk     (clk),
      .rst     (rst),
      .pause   (pause),
      .apply   (apply),
      .div_new (pend_div),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending      <= 1'b0;
         cfg_ready    <= 1'b1;
         pend_mode    <= '0;
         pend_div     <= '0;
         pend_pattern <= '0;
      end else if (accept) begin
         pending      <= 1'b1;
         cfg_ready    <= 1'b0;
         pend_mode    <= cfg_mode;
         pend_div     <= cfg_div;
         pend_pattern <= cfg_pattern;
      end else if (apply) begin
         pending      <= 1'b0;
         cfg_ready    <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_r   <= WIDTH'(1);
         pat_r   <= WIDTH'(1);
         mode_r  <= MODE_ROTL;
         dir_r   <= DIR_LEFT;
         phase_r <= 1'b0;
         step    <= 1'b0;
      end else begin
         step <= tick || apply;
         if (apply) begin
            led_r   <= pend_pattern;
            pat_r   <= pend_pattern;
            mode_r  <= pend_mode;
            dir_r   <= DIR_LEFT;
            phase_r <= 1'b0;
         end else if (tick) begin
            led_r   <= led_nxt;
            dir_r   <= dir_nxt;
            phase_r <= phase_nxt;
         end
      end
   end

   always_comb begin
      led_nxt   = led_r;
      dir_nxt   = dir_r;
      phase_nxt = phase_r;
      case (mode_r)
         MODE_ROTL: led_nxt = {led_r[WIDTH-2:0], led_r[WIDTH-1]};
         MODE_ROTR: led_nxt = {led_r[0], led_r[WIDTH-1:1]};
         MODE_BOUNCE: begin
            // An all-zero pattern shifts to itself and never flips, so it holds.
            if (dir_r == DIR_LEFT) begin
               if (led_r[WIDTH-1]) begin
                  dir_nxt = DIR_RIGHT;
                  led_nxt = led_r >> 1;
               end else begin
                  led_nxt = led_r << 1;
               end
            end else begin
               if (led_r[0]) begin
                  dir_nxt = DIR_LEFT;
                  led_nxt = led_r << 1;
               end else begin
                  led_nxt = led_r >> 1;
               end
            end
         end
         MODE_FILL: begin
            if (!phase_r) begin
               phase_nxt = (led_r == '1);
               led_nxt   = {led_r[WIDTH-2:0], (led_r != '1)};
            end else begin
               phase_nxt = (led_r != '0);
               led_nxt   = {led_r[WIDTH-2:0], (led_r == '0)};
            end
         end
         MODE_BLINK: begin
            phase_nxt = !phase_r;
            led_nxt   = phase_r ? pat_r : '0;
         end
         default: led_nxt = led_r;
      endcase
   end

   assign led  = led_r;
   assign mode = mode_r;

endmodule
